// File: rtl/muldiv_pkg.sv
// Shared definitions for the HI/LO multiply/divide sequencer.
// Contents: funct codes, FSM state encoding, divide-by-zero quotient constant,
// and funct classification helpers used by the FSM and the stall logic.
package muldiv_pkg;

  localparam int XLEN_DEF = 32;

  // R-type funct codes handled by the sequencer
  localparam logic [5:0] F_MFHI  = 6'd16;
  localparam logic [5:0] F_MTHI  = 6'd17;
  localparam logic [5:0] F_MFLO  = 6'd18;
  localparam logic [5:0] F_MTLO  = 6'd19;
  localparam logic [5:0] F_MULT  = 6'd24;
  localparam logic [5:0] F_MULTU = 6'd25;
  localparam logic [5:0] F_DIV   = 6'd26;
  localparam logic [5:0] F_DIVU  = 6'd27;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_MUL  = 3'd1,
    ST_DIV  = 3'd2,
    ST_FIX  = 3'd3,
    ST_DONE = 3'd4
  } state_e;

  // Quotient written to LO when the divisor is zero
  localparam logic [XLEN_DEF-1:0] DIV0_LO = '1;

  // MULT/MULTU/DIV/DIVU: starts a multi-cycle operation
  function automatic logic is_muldiv(input logic [5:0] f);
    return (f == F_MULT) || (f == F_MULTU) || (f == F_DIV) || (f == F_DIVU);
  endfunction

  // Any instruction that reads or writes HI/LO
  function automatic logic is_hilo(input logic [5:0] f);
    return (f == F_MFHI) || (f == F_MTHI) || (f == F_MFLO) || (f == F_MTLO) ||
           is_muldiv(f);
  endfunction

endpackage

// File: rtl/muldiv_datapath.sv
// Shift-add multiplier / restoring divider, one bit per iterate strobe.
// Latency: load, then XLEN iterate strobes, then one fix strobe; result valid after fix.
// No flow control: strobes come from the FSM, which owns sequencing and stalls.
// Ports: clk_i/rst_i; load_i/iter_i/fix_i strobes; is_div_i/is_signed_i op type at load;
//        op_a_i/op_b_i operands at load; hi_o/lo_o product or remainder/quotient.
module muldiv_datapath
  import muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            load_i,
  input  logic            iter_i,
  input  logic            fix_i,
  input  logic            is_div_i,
  input  logic            is_signed_i,
  input  logic [XLEN-1:0] op_a_i,
  input  logic [XLEN-1:0] op_b_i,
  output logic [XLEN-1:0] hi_o,
  output logic [XLEN-1:0] lo_o
);

  // acc holds {upper, lower}: {product hi, multiplier/product lo} for MUL,
  // {partial remainder, dividend/quotient} for DIV.
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0]   opb_q, opb_d;
  logic              is_div_q, neg_res_q, neg_rem_q, div0_q;

  logic              a_neg, b_neg;
  logic [XLEN-1:0]   mag_a, mag_b;
  logic [XLEN:0]     mul_add;
  logic [XLEN:0]     div_sh;
  logic [XLEN-1:0]   div_diff;
  logic              div_ge;
  logic [XLEN-1:0]   acc_hi, acc_lo, fix_hi, fix_lo;

  assign a_neg = is_signed_i & op_a_i[XLEN-1];
  assign b_neg = is_signed_i & op_b_i[XLEN-1];
  assign mag_a = a_neg ? (~op_a_i + 1'b1) : op_a_i;
  assign mag_b = b_neg ? (~op_b_i + 1'b1) : op_b_i;

  assign acc_hi = acc_q[2*XLEN-1:XLEN];
  assign acc_lo = acc_q[XLEN-1:0];

  // Multiply step: conditionally add multiplicand to the upper half, shift right.
  assign mul_add = {1'b0, acc_hi} + (acc_q[0] ? {1'b0, opb_q} : '0);

  // Divide step: shift next dividend bit into the remainder and trial-subtract.
  // When the subtract succeeds the true difference fits in XLEN bits.
  assign div_sh   = {acc_hi, acc_lo[XLEN-1]};
  assign div_ge   = div_sh >= {1'b0, opb_q};
  assign div_diff = div_sh[XLEN-1:0] - opb_q;

  always_comb begin
    fix_hi = acc_hi;
    fix_lo = acc_lo;
    if (is_div_q) begin
      fix_hi = neg_rem_q ? (~acc_hi + 1'b1) : acc_hi;
      // A zero divisor leaves |A| as remainder; restoring its sign yields the raw dividend.
      fix_lo = div0_q ? XLEN'(DIV0_LO) : (neg_res_q ? (~acc_lo + 1'b1) : acc_lo);
    end else if (neg_res_q) begin
      {fix_hi, fix_lo} = ~acc_q + 1'b1;
    end
  end

  always_comb begin
    acc_d = acc_q;
    opb_d = opb_q;
    if (load_i) begin
      acc_d = {{XLEN{1'b0}}, mag_a};
      opb_d = mag_b;
    end else if (iter_i) begin
      if (is_div_q) begin
        acc_d = div_ge ? {div_diff, acc_lo[XLEN-2:0], 1'b1}
                       : {div_sh[XLEN-1:0], acc_lo[XLEN-2:0], 1'b0};
      end else begin
        acc_d = {mul_add, acc_lo[XLEN-1:1]};
      end
    end else if (fix_i) begin
      acc_d = {fix_hi, fix_lo};
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      acc_q     <= '0;
      opb_q     <= '0;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      div0_q    <= 1'b0;
    end else begin
      acc_q <= acc_d;
      opb_q <= opb_d;
      if (load_i) begin
        is_div_q  <= is_div_i;
        neg_res_q <= a_neg ^ b_neg;
        neg_rem_q <= a_neg;
        div0_q    <= is_div_i && (op_b_i == '0);
      end
    end
  end

  assign hi_o = acc_hi;
  assign lo_o = acc_lo;

endmodule

// File: rtl/muldiv_ctrl.sv
// HI/LO owner and multi-cycle MULT/DIV sequencer for the EX stage.
// Latency: start at T, oDone in cycle T+XLEN+2, HI/LO written at the end of that cycle.
// Backpressure: oStall freezes IF/ID/EX while busy and EX holds a HI/LO or mul/div funct.
// Ports: iClk/iRst; iValid/iFunc/iOpA/iOpB instruction in EX; iFlush kills in-flight op;
//        oStall/oBusy/oDone status; oHI/oLO registers; oMfData MFHI/MFLO read data.
module muldiv_ctrl
  import muldiv_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = $clog2(XLEN) + 1
) (
  input  logic            iClk,
  input  logic            iRst,
  input  logic            iValid,
  input  logic [5:0]      iFunc,
  input  logic [XLEN-1:0] iOpA,
  input  logic [XLEN-1:0] iOpB,
  input  logic            iFlush,
  output logic            oStall,
  output logic            oBusy,
  output logic            oDone,
  output logic [XLEN-1:0] oHI,
  output logic [XLEN-1:0] oLO,
  output logic [XLEN-1:0] oMfData
);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [XLEN-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic [XLEN-1:0]   res_hi, res_lo;
  logic              start, load, iter, fix, done, busy, idle_ok;

  // Only an idle, unflushed sequencer accepts work; a busy one stalls it instead.
  assign idle_ok = (state_q == ST_IDLE) && iValid && !iFlush;
  assign start   = idle_ok && is_muldiv(iFunc);

  // State register
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  // Next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start) state_d = iFunc[1] ? ST_DIV : ST_MUL;
      ST_MUL,
      ST_DIV:  if (cnt_q == CNT_W'(1)) state_d = ST_FIX;
      ST_FIX:  state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (iFlush) state_d = ST_IDLE;
  end

  // Outputs / datapath strobes
  always_comb begin
    busy = (state_q != ST_IDLE);
    load = start;
    iter = ((state_q == ST_MUL) || (state_q == ST_DIV)) && !iFlush;
    fix  = (state_q == ST_FIX) && !iFlush;
    done = (state_q == ST_DONE) && !iFlush;
  end

  always_comb begin
    cnt_d = cnt_q;
    if (iFlush)    cnt_d = '0;
    else if (load) cnt_d = CNT_W'(XLEN);
    else if (iter) cnt_d = cnt_q - 1'b1;
  end

  always_comb begin
    hi_d = hi_q;
    lo_d = lo_q;
    if (done) begin
      hi_d = res_hi;
      lo_d = res_lo;
    end else if (idle_ok) begin
      if (iFunc == F_MTHI) hi_d = iOpA;
      if (iFunc == F_MTLO) lo_d = iOpA;
    end
  end

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      cnt_q <= '0;
      hi_q  <= '0;
      lo_q  <= '0;
    end else begin
      cnt_q <= cnt_d;
      hi_q  <= hi_d;
      lo_q  <= lo_d;
    end
  end

  muldiv_datapath #(.XLEN(XLEN)) u_dp (
    .clk_i       (iClk),
    .rst_i       (iRst),
    .load_i      (load),
    .iter_i      (iter),
    .fix_i       (fix),
    .is_div_i    (iFunc[1]),
    .is_signed_i (~iFunc[0]),
    .op_a_i      (iOpA),
    .op_b_i      (iOpB),
    .hi_o        (res_hi),
    .lo_o        (res_lo)
  );

  assign oBusy   = busy;
  assign oDone   = done;
  assign oStall  = busy && iValid && is_hilo(iFunc);
  assign oHI     = hi_q;
  assign oLO     = lo_q;
  assign oMfData = (iFunc == F_MFHI) ? hi_q : (iFunc == F_MFLO) ? lo_q : '0;

endmodule

// File: tb/tb_muldiv_ctrl.sv
module tb_muldiv_ctrl;

  logic        iClk = 1'b0;
  logic        iRst = 1'b1;
  logic        iValid = 1'b0;
  logic [5:0]  iFunc = '0;
  logic [31:0] iOpA = '0;
  logic [31:0] iOpB = '0;
  logic        iFlush = 1'b0;
  logic        oStall, oBusy, oDone;
  logic [31:0] oHI, oLO, oMfData;

  muldiv_ctrl dut (
    .iClk(iClk), .iRst(iRst), .iValid(iValid), .iFunc(iFunc),
    .iOpA(iOpA), .iOpB(iOpB), .iFlush(iFlush),
    .oStall(oStall), .oBusy(oBusy), .oDone(oDone),
    .oHI(oHI), .oLO(oLO), .oMfData(oMfData)
  );

  always #5 iClk = ~iClk;

  int cyc = 0;
  always @(posedge iClk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          cyc;
  } exp_t;

  exp_t        sb[$];
  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] hi_m = '0;
  logic [31:0] lo_m = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: plain arithmetic on the architectural definition.
  task automatic model(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] h, output logic [31:0] l);
    int          sa, sbv;
    longint      ps;
    logic [63:0] pu;
    sa = a; sbv = b;
    h = 0; l = 0;
    case (f)
      6'd24: begin ps = longint'(sa) * longint'(sbv); h = ps[63:32]; l = ps[31:0]; end
      6'd25: begin pu = {32'd0, a} * {32'd0, b}; h = pu[63:32]; l = pu[31:0]; end
      6'd26: begin
        if (b == 0) begin h = a; l = 32'hFFFF_FFFF; end
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin h = 0; l = 32'h8000_0000; end
        else begin l = sa / sbv; h = sa % sbv; end
      end
      6'd27: begin
        if (b == 0) begin h = a; l = 32'hFFFF_FFFF; end
        else begin l = a / b; h = a % b; end
      end
      default: ;
    endcase
  endtask

  // Monitor: pops on every oDone, checks timing, then HI/LO in the following cycle.
  exp_t pend;
  bit   chk_pending = 0;
  always @(negedge iClk) begin
    if (chk_pending) begin
      chk_pending = 0;
      check("done_pulse_width", {31'd0, oDone}, 32'd0);
      check("HI", oHI, pend.hi);
      check("LO", oLO, pend.lo);
    end
    if (!iRst && oDone) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        pend = sb.pop_front();
        check("done_cycle", cyc, pend.cyc);
        chk_pending = 1;
      end
    end
  end

  // Drive one instruction for one cycle; returns its issue cycle.
  task automatic issue(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                       input bit track, output int t);
    exp_t e;
    @(posedge iClk); #1;
    iValid = 1; iFunc = f; iOpA = a; iOpB = b;
    t = cyc;
    if (track) begin
      if (f >= 6'd24 && f <= 6'd27) begin
        model(f, a, b, e.hi, e.lo);
        e.cyc = t + 34;
        sb.push_back(e);
        hi_m = e.hi; lo_m = e.lo;
      end else if (f == 6'd17) hi_m = a;
      else if (f == 6'd19) lo_m = a;
    end
    @(posedge iClk); #1;
    iValid = 0; iFunc = 0;
  endtask

  task automatic wait_idle();
    int k = 0;
    do begin @(negedge iClk); k++; end while (oBusy && k < 80);
    check("idle_timeout", {31'd0, oBusy}, 32'd0);
  endtask

  task automatic run(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    int t;
    issue(f, a, b, 1, t);
    wait_idle();
  endtask

  // MFHI/MFLO read-back in IDLE: combinational, never stalled.
  task automatic readback();
    @(posedge iClk); #1;
    iValid = 1; iFunc = 6'd16;
    @(negedge iClk);
    check("mfhi_data", oMfData, hi_m);
    check("mfhi_stall", {31'd0, oStall}, 32'd0);
    @(posedge iClk); #1;
    iFunc = 6'd18;
    @(negedge iClk);
    check("mflo_data", oMfData, lo_m);
    @(posedge iClk); #1;
    iValid = 0; iFunc = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    logic [5:0]  flist[6];
    logic [31:0] corner[6];
    flist  = '{6'd24, 6'd25, 6'd26, 6'd27, 6'd17, 6'd19};
    corner = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'd7};

    // Reset state
    #1;
    check("rst_busy", {31'd0, oBusy}, 32'd0);
    check("rst_stall", {31'd0, oStall}, 32'd0);
    check("rst_done", {31'd0, oDone}, 32'd0);
    check("rst_hi", oHI, 32'd0);
    check("rst_lo", oLO, 32'd0);
    repeat (3) @(posedge iClk);
    #1 iRst = 0;

    // Give HI/LO nonzero content, then reset mid-MULTU
    issue(6'd17, 32'hAAAA_5555, 0, 1, t);
    issue(6'd19, 32'h1357_9BDF, 0, 1, t);
    issue(6'd25, 32'd3, 32'd5, 0, t);
    repeat (9) @(posedge iClk);
    #3 iRst = 1;
    #1;
    check("midrst_busy", {31'd0, oBusy}, 32'd0);
    check("midrst_hi", oHI, 32'd0);
    check("midrst_lo", oLO, 32'd0);
    hi_m = 0; lo_m = 0;
    @(posedge iClk); #1 iRst = 0;
    run(6'd25, 32'd3, 32'd5);

    // Directed arithmetic corners
    run(6'd24, 32'hFFFF_FFFF, 32'd7);
    run(6'd25, 32'hFFFF_FFFF, 32'd7);
    run(6'd26, 32'hFFFF_FFF9, 32'd2);
    run(6'd27, 32'd100, 32'd0);
    run(6'd26, 32'h8000_0000, 32'hFFFF_FFFF);
    run(6'd26, 32'hFFFF_FF9C, 32'd0);
    readback();

    // Independent op during busy, then dependent MFLO stalled through DONE
    issue(6'd24, 32'h0001_2345, 32'hFFFF_0F0F, 1, t);
    iValid = 1; iFunc = 6'd32;
    @(negedge iClk);
    check("add_no_stall", {31'd0, oStall}, 32'd0);
    check("busy_during_op", {31'd0, oBusy}, 32'd1);
    @(posedge iClk); #1;
    iValid = 0; iFunc = 0;
    repeat (3) @(posedge iClk);
    #1 iValid = 1; iFunc = 6'd18;
    for (int k = 5; k <= 35; k++) begin
      @(negedge iClk);
      check("mflo_stall", {31'd0, oStall}, (t + k <= t + 34) ? 32'd1 : 32'd0);
      if (k == 35) check("mflo_after_done", oMfData, lo_m);
      else begin @(posedge iClk); #1; end
    end
    @(posedge iClk); #1 iValid = 0; iFunc = 0;

    // Flush at cycle 20 of DIVU together with an ignored start
    issue(6'd27, 32'hDEAD_BEEF, 32'd3, 0, t);
    repeat (18) @(posedge iClk);
    #1 iFlush = 1; iValid = 1; iFunc = 6'd24; iOpA = 32'd9; iOpB = 32'd9;
    @(posedge iClk); #1 iFlush = 0; iValid = 0; iFunc = 0;
    @(negedge iClk);
    check("flush_idle", {31'd0, oBusy}, 32'd0);
    repeat (40) @(posedge iClk);
    @(negedge iClk);
    check("flush_hi", oHI, hi_m);
    check("flush_lo", oLO, lo_m);

    // MTHI then MFHI back-to-back in IDLE
    @(posedge iClk); #1 iValid = 1; iFunc = 6'd17; iOpA = 32'h1234;
    @(negedge iClk);
    check("mthi_stall", {31'd0, oStall}, 32'd0);
    hi_m = 32'h1234;
    @(posedge iClk); #1 iFunc = 6'd16;
    @(negedge iClk);
    check("mfhi_b2b", oMfData, 32'h1234);
    check("mfhi_b2b_stall", {31'd0, oStall}, 32'd0);
    @(posedge iClk); #1 iValid = 0; iFunc = 0;

    // Randomized sequence against the model
    for (int n = 0; n < 40; n++) begin
      logic [5:0]  f;
      logic [31:0] a, b;
      f = flist[$urandom_range(0, 5)];
      a = ($urandom_range(0, 2) == 0) ? corner[$urandom_range(0, 5)] : $urandom;
      case ($urandom_range(0, 3))
        0: b = corner[$urandom_range(0, 5)];
        1: b = $urandom_range(0, 15);
        default: b = $urandom;
      endcase
      if (f == 6'd17 || f == 6'd19) issue(f, a, b, 1, t);
      else run(f, a, b);
      readback();
    end

    repeat (3) @(posedge iClk);
    check("scoreboard_empty", sb.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/muldiv_ctrl.md
Name: muldiv_ctrl

Overview:
- Iterative multiply/divide sequencer for the EX stage of the 5-stage MIPS pipeline; owns the HI/LO registers.
- Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO/MFHI/MFLO (R-type, decoded by funct) alongside the single-cycle ALU path.
- Holds the pipeline via a stall output while a multi-cycle operation is in flight and a dependent HI/LO instruction arrives.
- Sub-tasks: a radix-2 shift-add multiply and a restoring divide, one bit per cycle.

Parameters:
- XLEN, 32, operand width; HI and LO are XLEN each.
- CNT_W, $clog2(XLEN)+1, iteration counter width.

Ports:
- iClk  in  1  clock
- iRst  in  1  asynchronous reset, active-high
- iValid  in  1  EX holds a valid R-type instruction this cycle, not stalled or flushed
- iFunc  in  6  funct field of that instruction
- iOpA  in  XLEN  rs value after forwarding
- iOpB  in  XLEN  rt value after forwarding
- iFlush  in  1  kill any in-flight operation (exception/mispredict recovery)
- oStall  out  1  freeze IF/ID/EX this cycle
- oBusy  out  1  multi-cycle operation in flight
- oDone  out  1  one-cycle pulse when HI/LO update from MULT/DIV
- oHI  out  XLEN  HI register
- oLO  out  XLEN  LO register
- oMfData  out  XLEN  HI for MFHI, LO for MFLO, else 0

Behaviour:
- Functs: MULT 24, MULTU 25, DIV 26, DIVU 27, MFHI 16, MTHI 17, MFLO 18, MTLO 19. All other functs are ignored.
- Reset (async, iRst=1):
  - State IDLE; HI=LO=0; counter=0.
  - oStall, oBusy and oDone are 0.
  - Reset mid-operation discards the operation.
- FSM states: IDLE, MUL, DIV, FIX, DONE.
- Start: IDLE, iValid, funct in {24..27} at cycle T.
  - Latch |A| and |B| (magnitudes when signed, raw when unsigned), the sign flags and the op type.
  - Counter=XLEN; go to MUL or DIV.
- MUL and DIV: one iteration per cycle, XLEN cycles.
  - MUL: 2*XLEN product register, shift-add.
  - DIV: restoring divide; remainder/quotient shift register.
  - At counter==1, go to FIX.
- FIX (1 cycle): apply signs for signed ops.
  - Product negated if the signs differ.
  - Quotient negated if the signs differ.
  - Remainder takes the sign of the dividend.
  - Go to DONE.
- DONE (1 cycle): HI<=upper/remainder, LO<=lower/quotient; oDone=1; go to IDLE.
- Total latency: start at T, HI/LO visible at T+XLEN+2 (T+34).
- oBusy=1 in MUL, DIV, FIX and DONE.
- oStall = oBusy && iValid && funct in {16..19, 24..27}. Independent instructions are never stalled.
- MTHI/MTLO in IDLE: HI (resp. LO) <= iOpA at the next edge; no stall.
- MFHI/MFLO: oMfData is combinational from the current HI/LO.
  - Issued in the DONE cycle, it is stalled one cycle and then sees the new values.
- Divide by zero: no trap; HI=dividend (iOpA as latched), LO=all ones. Applies to signed and unsigned.
- Signed DIV of 0x80000000 by 0xFFFFFFFF: LO=0x80000000, HI=0 (falls out of the magnitude algorithm; required).
- iFlush: highest priority after reset.
  - Any state returns to IDLE next cycle; HI/LO unchanged; oDone not pulsed.
  - A start in the same cycle as iFlush is ignored.
- A start request while oBusy is already covered by oStall; never double-accepted.
- All arithmetic is unsigned on magnitudes; no X propagation on unused bits.

Decomposition:
- Shared package:
  - funct localparams for the eight functs.
  - FSM state encoding: IDLE=0, MUL=1, DIV=2, FIX=3, DONE=4.
  - Divide-by-zero LO constant.
- One natural sub-module, muldiv_datapath: product/remainder shift registers and the adder/subtractor, stepped by the FSM's iterate/load/fix strobes.
- The FSM, HI/LO registers and stall logic stay in muldiv_ctrl.

Test Plan:
- Reset mid-MUL (iRst at cycle 10): oBusy=0 immediately, HI=LO=0. A fresh MULTU 3×5 then gives LO=15, HI=0 at T+34.
- MULT 0xFFFFFFFF (−1) × 7: HI=0xFFFFFFFF, LO=0xFFFFFFF9, oDone pulse exactly at T+34. Same operands as MULTU: HI=0x00000006, LO=0xFFFFFFF9.
- DIV −7 / 2: LO=0xFFFFFFFD (−3), HI=0xFFFFFFFF (−1). DIVU 100/0: HI=100, LO=0xFFFFFFFF. DIV 0x80000000/0xFFFFFFFF: LO=0x80000000, HI=0.
- MFLO issued 5 cycles after MULT: oStall high through DONE, then oMfData equals the new LO. An ADD issued during busy: oStall=0.
- iFlush at cycle 20 of DIVU: IDLE next cycle, no oDone, HI/LO keep prior values.
- MTHI 0x1234 then MFHI back-to-back in IDLE: oMfData=0x1234 in the MFHI cycle, no stall.
